instr_fetch: RTL and testbench

Instruction-fetch stage that drives the word-aligned instruction memory from the read side. Holds the program counter, presents it as the memory byte address, and captures the returned instruction into an IF/ID pipeline register. Accepts stall, branch and jump redirects from decode, and a halt request. Sits between the instruction memory (32 words, combinational read, byte address bits [6:2]) and the decode stage.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/instr_fetch_next_pc_sel.sv | 39 +++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Types and constants shared by the fetch stage and decode: FSM encoding,
// the NOP word, opcode values and the word-alignment helper.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_LW    = 6'b100011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC priority mux: branch, then jump, then hold on stall, then PC+4.
// Builds the aligned branch target and the J-format jump target.
module next_pc_sel
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  pc4_hi,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] br_addr;
  logic [31:0] jmp_addr;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_addr  = word_align(br_target);
    // Jump region comes from the PC+4 held in IF/ID, not the current PC.
    jmp_addr = {pc4_hi, jmp_index, 2'b00};
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (br_taken) begin
      next_pc  = br_addr;
      redirect = 1'b1;
    end else if (jmp) begin
      next_pc  = jmp_addr;
      redirect = 1'b1;
    end else if (stall) begin
      next_pc  = pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, instruction memory address, IF/ID register.
//   state   | meaning
//   BOOT    | one post-reset cycle, PC=RESET_PC, nothing fetched
//   RUN     | fetching; redirects, stall and halt honoured
//   HALT    | frozen until reset, IF/ID holds a bubble
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        halt,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        halted
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;

  next_pc_sel u_next_pc_sel (
    .pc        (pc_q),
    .pc4_hi    (pc4_q[31:28]),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_index (jmp_index),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc),
    .redirect  (redirect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (redirect) begin
          // The instruction at the old PC is squashed, even under stall.
          pc_d    = next_pc;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = next_pc;
          instr_d = imem_instr;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc4    = pc4_q;
  assign if_valid  = valid_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural fetch model pushes the
// expected post-edge outputs for each driven cycle; each scenario pops and compares.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        halt;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  assign imem_instr = mem[imem_addr[6:2]];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_index  (jmp_index),
    .halt       (halt),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4),
    .if_valid   (if_valid),
    .halted     (halted)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } obs_t;

  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int          m_state;  // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  function automatic obs_t observe();
    obs_t o;
    o.pc = imem_addr; o.instr = if_instr; o.pc4 = if_pc4; o.valid = if_valid; o.halted = halted;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle from posedge+1, advance the model, push its prediction.
  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji, input logic h);
    obs_t e;
    stall = st; br_taken = br; br_target = bt; jmp = j; jmp_index = ji; halt = h;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (h) begin
          m_state = 2; m_instr = 32'h0; m_valid = 1'b0;
        end else if (br) begin
          m_pc = {bt[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
        end else if (j) begin
          m_pc = {m_pc4[31:28], ji, 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
          m_instr = mem[m_pc[6:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end
      default: ;
    endcase
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, halted: (m_state == 2)};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_index = 0; halt = 0;
    model_reset();
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0}) begin
      failures++;
      $display("FAIL reset_immediate got addr=%h instr=%h pc4=%h v=%b h=%b", got.pc, got.instr, got.pc4, got.valid, got.halted);
    end
    @(posedge clk); #1;
    got = observe();
    checks++;
    if (got !== obs_t'{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0}) begin
      failures++;
      $display("FAIL reset_held got addr=%h instr=%h pc4=%h v=%b h=%b", got.pc, got.instr, got.pc4, got.valid, got.halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    obs_t e, got;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 26'h0, 0);
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL seq[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_stall();
    obs_t e, got;
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 0, 32'h0, 0, 26'h0, 0);
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL stall[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_jump();
    obs_t e, got;
    for (int i = 0; i < 7; i++) begin
      // five fetches bring if_pc4 to 0x24, then jump to index 3, then refill
      drive(0, 0, 32'h0, i == 5, (i == 5) ? 26'd3 : 26'h0, 0);
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL jump[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_branch_priority();
    obs_t e, got;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1, 1, 32'h0000_001B, 1, 26'h155, 0);
      else        drive(0, 0, 32'h0, 0, 26'h0, 0);
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL branch[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, got;
    for (int i = 0; i < 3; i++) begin
      drive(0, i == 0, 32'hFFFF_FFFF, 0, 26'h0, 0);
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL wrap[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_halt();
    obs_t e, got;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(0, 1, 32'h0000_0020, 0, 26'h0, 0);
        1: drive(1, 1, 32'h0000_0040, 1, 26'h7, 1);
        2: drive(0, 1, 32'h0000_0040, 0, 26'h0, 0);
        3: drive(0, 0, 32'h0, 1, 26'h9, 0);
        default: drive(0, 0, 32'h0, 0, 26'h0, 0);
      endcase
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL halt[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, got;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = observe(); checks++;
    if (got !== obs_t'{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0}) begin
      failures++;
      $display("FAIL async_reset got addr=%h instr=%h pc4=%h v=%b h=%b", got.pc, got.instr, got.pc4, got.valid, got.halted);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 26'h0, 0);
      e = sb.pop_front(); got = observe(); checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL restart[%0d] got addr=%h instr=%h pc4=%h v=%b h=%b exp addr=%h instr=%h pc4=%h v=%b h=%b",
                 i, got.pc, got.instr, got.pc4, got.valid, got.halted, e.pc, e.instr, e.pc4, e.valid, e.halted);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i * 16'h0101);
    mem[0] = 32'h8C08_0000;
    mem[1] = 32'h8C09_0001;
    mem[2] = 32'h8C0C_000B;
    mem[3] = 32'h012C_5822;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
